spimemio_cache: RTL and testbench

//  Direct-mapped, read-only word cache between the CPU flash window and spimemio.
//  CPU side speaks the spimemio valid/ready/addr/rdata protocol; misses are forwarded

---
 rtl/spimemio_cache.sv | 176 +++++++++++++++++
 tb/tb_spimemio_cache.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spimemio_cache.sv
// ---------------------------------------------------------------------------
// spimemio_cache
//   Direct-mapped, read-only word cache between the CPU flash window and
//   spimemio. Hits answer in one cycle without touching SPI; misses are
//   forwarded to spimemio as a single word request and the returned word is
//   installed unless a flush arrived while the fill was outstanding.
//
//   Optional feature macro: SPIMEMIO_CACHE_STATS_EN
//     When defined, hit_count/miss_count ports and counters are present.
//
// Ports
//   clk        in   1   clock
//   reset      in   1   asynchronous, active-high reset
//   flush      in   1   invalidate all entries (pulse or level)
//   valid      in   1   CPU read request, held until ready
//   ready      out  1   one-cycle response strobe
//   addr       in   24  CPU byte address (addr[1:0] ignored)
//   rdata      out  32  read data, valid while ready=1
//   mem_valid  out  1   request to spimemio
//   mem_ready  in   1   spimemio response strobe
//   mem_addr   out  24  word-aligned address of the missing word
//   mem_rdata  in   32  spimemio read data
//   hit_count  out  32  hit counter   (SPIMEMIO_CACHE_STATS_EN only)
//   miss_count out  32  miss counter  (SPIMEMIO_CACHE_STATS_EN only)
// ---------------------------------------------------------------------------
module spimemio_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [23:0] mem_addr,
  input  logic [31:0] mem_rdata
`ifdef SPIMEMIO_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 22 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t state, state_next;

  logic [31:0]         data_mem [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem  [ENTRIES];
  logic [ENTRIES-1:0]  vld;
  logic                flush_pend;

  logic [INDEX_BITS-1:0] lookup_idx, fill_idx;
  logic [TAG_BITS-1:0]   lookup_tag, fill_tag;
  logic                  lookup_hit;

  logic        ready_next, mem_valid_next, flush_pend_next, fill_write;
  logic [31:0] rdata_next;
  logic [23:0] mem_addr_next;

  // Byte offset within a word never affects the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[1:0]};

  assign lookup_idx = addr[INDEX_BITS+1:2];
  assign lookup_tag = addr[23:INDEX_BITS+2];
  // The fill is installed at the address held on mem_addr, which stays
  // stable for the whole fill, so the CPU address is not needed afterwards.
  assign fill_idx   = mem_addr[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr[23:INDEX_BITS+2];
  // Lookup uses the pre-flush vld, so a same-cycle flush still lets a hit
  // through; flush only changes the access mode, not the flash contents.
  assign lookup_hit = vld[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

  always_comb begin
    state_next      = state;
    ready_next      = 1'b0;
    rdata_next      = rdata;
    mem_valid_next  = mem_valid;
    mem_addr_next   = mem_addr;
    flush_pend_next = flush_pend;
    fill_write      = 1'b0;
    case (state)
      IDLE: begin
        if (valid && !ready) begin
          if (lookup_hit) begin
            ready_next = 1'b1;
            rdata_next = data_mem[lookup_idx];
            state_next = RESP;
          end else begin
            mem_valid_next = 1'b1;
            mem_addr_next  = {addr[23:2], 2'b00};
            state_next     = FILL;
          end
        end
      end
      FILL: begin
        // A flush while the word is in flight means it may have been read
        // under the old mode; return it but do not keep it.
        if (flush) flush_pend_next = 1'b1;
        if (mem_ready) begin
          mem_valid_next  = 1'b0;
          rdata_next      = mem_rdata;
          ready_next      = 1'b1;
          fill_write      = !flush_pend && !flush;
          flush_pend_next = 1'b0;
          state_next      = RESP;
        end
      end
      RESP: begin
        // No lookup here: the CPU gets one cycle to drop or change valid.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      rdata      <= 32'd0;
      mem_valid  <= 1'b0;
      mem_addr   <= 24'd0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_next;
      ready      <= ready_next;
      rdata      <= rdata_next;
      mem_valid  <= mem_valid_next;
      mem_addr   <= mem_addr_next;
      flush_pend <= flush_pend_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (fill_write) begin
      vld[fill_idx] <= 1'b1;
    end
  end

  // Data and tag storage is never reset; vld alone guards it.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      data_mem[fill_idx] <= mem_rdata;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

`ifdef SPIMEMIO_CACHE_STATS_EN
  logic hit_event, miss_event;
  assign hit_event  = (state == IDLE) && valid && !ready && lookup_hit;
  assign miss_event = (state == IDLE) && valid && !ready && !lookup_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_event)  hit_count  <= hit_count + 32'd1;
      if (miss_event) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spimemio_cache.sv
module tb_spimemio_cache;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [23:0] addr;
  logic [31:0] rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;
`ifdef SPIMEMIO_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  // Flash contents seen by the spimemio stand-in, keyed by word address.
  logic [31:0] flash [logic [21:0]];

  int          resp_lat = 0;
  int          req_count = 0;
  int          addr_moved = 0;
  logic [23:0] last_req_addr = 24'd0;

  // Cache model: which word address each line holds (-1 = empty) and its data.
  int          line_addr [16];
  logic [31:0] line_data [16];
  int          model_hits = 0;
  int          model_misses = 0;

  spimemio_cache #(.INDEX_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .valid     (valid),
    .ready     (ready),
    .addr      (addr),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
`ifdef SPIMEMIO_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] flash_read(logic [23:0] a);
    if (flash.exists(a[23:2])) return flash[a[23:2]];
    return {a[23:2], 10'h2A5} ^ 32'h13579BDF;
  endfunction

  // spimemio stand-in: answers resp_lat full cycles after seeing mem_valid,
  // gives up if mem_valid disappears (reset).
  initial begin
    bit aborted;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_valid && !reset) begin
        req_count++;
        last_req_addr = mem_addr;
        aborted = 1'b0;
        for (int i = 0; i < resp_lat; i++) begin
          @(negedge clk);
          if (!mem_valid) begin
            aborted = 1'b1;
            break;
          end
          if (mem_addr != last_req_addr) addr_moved++;
        end
        if (!aborted) begin
          mem_ready = 1'b1;
          mem_rdata = flash_read(last_req_addr);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // One CPU read; flush_k<0 no flush, 0 flush with the request, k>0 flush
  // sampled on the k-th edge after the request edge.
  task automatic apply_stimulus(input logic [23:0] a, input int lat, input int flush_k,
                                output logic [31:0] data, output int cycles,
                                output int reqs, output logic ready_after,
                                output bit timed_out);
    int req0;
    resp_lat = lat;
    @(negedge clk);
    req0  = req_count;
    valid = 1'b1;
    addr  = a;
    if (flush_k >= 0) begin
      fork
        begin
          if (flush_k > 0) begin
            repeat (flush_k) @(posedge clk);
            @(negedge clk);
          end
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
        end
      join_none
    end
    timed_out = 1'b1;
    cycles    = 0;
    data      = 32'd0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        cycles    = c;
        data      = rdata;
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    ready_after = ready;
    wait fork;
    reqs = req_count - req0;
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int lat,
                         input int flush_k, input bit exp_hit, input logic [31:0] exp_data);
    logic [31:0] d;
    int          cyc, reqs, moved0;
    logic        ra;
    bit          to;
    moved0 = addr_moved;
    apply_stimulus(a, lat, flush_k, d, cyc, reqs, ra, to);
    check_output({tag, "_timeout"}, 32'(to), 32'd0);
    check_output({tag, "_rdata"}, d, exp_data);
    check_output({tag, "_latency"}, cyc, exp_hit ? 1 : lat + 2);
    check_output({tag, "_requests"}, reqs, exp_hit ? 0 : 1);
    check_output({tag, "_ready_width"}, 32'(ra), 32'd0);
    check_output({tag, "_addr_stable"}, addr_moved - moved0, 0);
    if (!exp_hit) check_output({tag, "_mem_addr"}, 32'(last_req_addr), 32'({a[23:2], 2'b00}));
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  typedef struct {
    logic [23:0] addr;
    int          lat;
    int          flush_k;
    bit          flush_before;
    bit          set_flash;
    logic [23:0] set_addr;
    logic [31:0] set_val;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  initial begin
    bit          hit, ok;
    int          lat, fk, idx;
    logic [23:0] a, waddr;
    logic [31:0] exp;

    reset = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    addr  = 24'd0;

    flash[22'(24'h100000 >> 2)] = 32'hDEADBEEF;
    flash[22'(24'h100040 >> 2)] = 32'h12345678;
    flash[22'(24'h200000 >> 2)] = 32'hA5A5F00D;
    flash[22'(24'hFFFFFC >> 2)] = 32'h0BADCAFE;

    vecs[0]  = '{24'h100000, 20, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{24'h100002, 20, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{24'h100000,  3, -1, 1'b1, 1'b0, 24'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{24'h100040,  3, -1, 1'b0, 1'b1, 24'h100000, 32'hCAFEF00D, 1'b0, 32'h12345678};
    vecs[4]  = '{24'h100000,  3, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'hCAFEF00D};
    vecs[5]  = '{24'h200000,  8,  3, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'hA5A5F00D};
    vecs[6]  = '{24'h200000,  2, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'hA5A5F00D};
    vecs[7]  = '{24'h200000,  2, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 32'hA5A5F00D};
    vecs[8]  = '{24'hFFFFFC,  1, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'h0BADCAFE};
    vecs[9]  = '{24'hFFFFFF,  1, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 32'h0BADCAFE};
    vecs[10] = '{24'h200000,  0,  0, 1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 32'hA5A5F00D};
    vecs[11] = '{24'h200000,  0, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'hA5A5F00D};
    vecs[12] = '{24'hFFFFFC,  1, -1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 32'h0BADCAFE};

    repeat (3) @(negedge clk);
    #1;
    check_output("reset_ready", 32'(ready), 32'd0);
    check_output("reset_mem_valid", 32'(mem_valid), 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
`ifdef SPIMEMIO_CACHE_STATS_EN
    check_output("reset_hit_count", hit_count, 32'd0);
    check_output("reset_miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].flush_before) pulse_flush();
      if (vecs[i].set_flash) flash[vecs[i].set_addr[23:2]] = vecs[i].set_val;
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].flush_k,
              vecs[i].exp_hit, vecs[i].exp_data);
      if (i == 4) begin
`ifdef SPIMEMIO_CACHE_STATS_EN
        check_output("stats_hits", hit_count, 32'd1);
        check_output("stats_misses", miss_count, 32'd4);
`endif
        pulse_flush();
`ifdef SPIMEMIO_CACHE_STATS_EN
        check_output("stats_hits_after_flush", hit_count, 32'd1);
        check_output("stats_misses_after_flush", miss_count, 32'd4);
`endif
      end
    end

    $display("[TB] async reset during fill");
    resp_lat = 30;
    @(negedge clk);
    valid = 1'b1;
    addr  = 24'h400000;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (mem_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("rst_req_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_mem_valid_drop", 32'(mem_valid), 32'd0);
    check_output("rst_ready_low", 32'(ready), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ok = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ready || mem_valid) ok = 1'b1;
    end
    check_output("rst_no_late_response", 32'(ok), 32'd0);
    do_read("rst_next", 24'h400000, 2, -1, 1'b0, flash_read(24'h400000));

    for (int i = 0; i < 16; i++) line_addr[i] = -1;
    model_hits   = 0;
    model_misses = 1;
    line_addr[0] = 32'h400000;
    line_data[0] = flash_read(24'h400000);

    $display("[TB] randomized reads");
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        waddr = 24'hFFFFC0 + 24'($urandom_range(0, 15) << 2);
      else
        waddr = 24'h300000 + 24'($urandom_range(0, 3) << 6) + 24'($urandom_range(0, 7) << 2);
      a   = waddr + 24'($urandom_range(0, 3));
      lat = $urandom_range(0, 4);
      idx = int'(waddr[5:2]);
      hit = (line_addr[idx] == int'(waddr));
      case ($urandom_range(0, 9))
        0:       fk = 0;
        1:       fk = hit ? -1 : $urandom_range(1, lat + 1);
        default: fk = -1;
      endcase
      exp = hit ? line_data[idx] : flash_read(waddr);
      do_read($sformatf("rnd%0d", n), a, lat, fk, hit, exp);
      if (hit) model_hits++;
      else     model_misses++;
      if (fk >= 0)
        for (int j = 0; j < 16; j++) line_addr[j] = -1;
      if (!hit && fk <= 0) begin
        line_addr[idx] = int'(waddr);
        line_data[idx] = exp;
      end
    end
`ifdef SPIMEMIO_CACHE_STATS_EN
    check_output("rnd_hit_count", hit_count, 32'(model_hits));
    check_output("rnd_miss_count", miss_count, 32'(model_misses));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
